// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction queue: a small FIFO of {PC, instr} pairs with
// valid/ready handshakes on both sides, a redirect flush, and a PC+4 output.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter int          PTR_W    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_pc4,
  output logic [31:0]      out_instr,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0]   DEPTH_C  = DEPTH[PTR_W:0];
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W:0]   count_reg, count_next;
  logic             push, pop;

  logic [31:0] pc_mem    [DEPTH];
  logic [31:0] instr_mem [DEPTH];

  // Handshake flags depend only on registered occupancy, never on the
  // opposite side's ready/valid input.
  assign in_ready  = (count_reg < DEPTH_C);
  assign out_valid = (count_reg != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    count_next  = count_reg;
    if (flush) begin
      rd_ptr_next = '0;
      wr_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push) wr_ptr_next = ptr_inc(wr_ptr_reg);
      if (pop)  rd_ptr_next = ptr_inc(rd_ptr_reg);
      if (push && !pop)      count_next = count_reg + 1'b1;
      else if (pop && !push) count_next = count_reg - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Storage is deliberately left uncleared; the empty mux hides stale data.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (!reset && push && (wr_ptr_reg == PTR_W'(gi))) begin
        pc_mem[gi]    <= in_pc;
        instr_mem[gi] <= in_instr;
      end
    end
  end

  assign out_pc    = out_valid ? pc_mem[rd_ptr_reg]    : RESET_PC;
  assign out_instr = out_valid ? instr_mem[rd_ptr_reg] : 32'h0000_0000;
  assign out_pc4   = out_pc + 32'd4;
  assign count     = count_reg;

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Small synchronous FIFO between the instruction fetch unit and the decode/controller stage; stores fetched {PC, Instr} pairs.
- Decouples fetch from decode stalls using a valid/ready handshake on both sides.
- On a control-flow redirect (branch/jump/jr resolved), the flush input discards every queued instruction.
- Presents PC+4 alongside each instruction for jal link-value generation downstream.

Parameters:
- DEPTH, 4, number of entries; power of two, 2..16.
- PTR_W, 2, pointer width, equal to log2(DEPTH).
- RESET_PC, 32'h0000_3000, value reported on out_pc while the queue is empty.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  discard all entries at this edge.
- in_valid  input  1  fetch presents a valid instruction.
- in_ready  output  1  queue can accept; equals (count < DEPTH); registered-state only, no combinational path from out_ready.
- in_pc  input  32  PC of the incoming instruction.
- in_instr  input  32  incoming instruction word.
- out_valid  output  1  head entry valid; equals (count != 0).
- out_ready  input  1  decode consumes the head this cycle.
- out_pc  output  32  head PC; RESET_PC when empty.
- out_pc4  output  32  head PC + 4, modulo 2^32; RESET_PC + 4 when empty.
- out_instr  output  32  head instruction; 32'h0000_0000 (nop) when empty.
- count  output  PTR_W+1  current occupancy, range 0..DEPTH.

Behaviour:
- Reset (synchronous, evaluated at posedge clk with reset=1):
  - rd_ptr, wr_ptr and count are all cleared to 0.
  - Resulting outputs: out_valid=0, in_ready=1, out_pc=RESET_PC, out_pc4=RESET_PC+4, out_instr=0.
  - Reset overrides flush, push and pop issued in the same cycle.
  - A reset arriving mid-stream discards all entries, exactly like a flush.
- Push condition: in_valid && in_ready && !flush. Action: write {in_pc, in_instr} at wr_ptr, then advance wr_ptr (wraps DEPTH-1 -> 0).
- Pop condition: out_valid && out_ready && !flush. Action: advance rd_ptr (same wrap rule).
- Count update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous push and pop.
- Full (count=DEPTH):
  - in_ready=0, so no push occurs regardless of out_ready.
  - A pop in the same cycle frees one slot; in_ready rises the following cycle.
- Empty (count=0):
  - out_valid=0, and out_ready is ignored.
  - Bypass is not allowed: a pushed word becomes visible on the outputs one cycle after the push edge (latency 1).
- Flush:
  - At the edge where flush=1: rd_ptr=wr_ptr=0 and count=0.
  - Any push or pop in that same cycle is dropped.
  - Outputs show the empty values from the next cycle on.
  - Flush while empty is a no-op.
- Output path:
  - out_pc, out_pc4 and out_instr are combinational reads of the storage entry at rd_ptr, muxed to the empty values when count=0.
  - out_pc4 uses a 32-bit adder; carry-out is discarded.
- Storage contents are not cleared by reset or flush; only the pointers and count are.
- The design must not produce X on any output after reset.
- Holding in_valid=1 while in_ready=0 is legal. The fetch unit holds its PC and the queue takes no action.

Test Plan:
- Reset, then push PC=0x3000/0x34080001 and PC=0x3004/0x34090002 with out_ready=0 -> count=2; out_pc=0x3000, out_pc4=0x3004, out_instr=0x34080001.
- Push 4 entries with out_ready=0 (DEPTH=4) -> in_ready=0 and count=4. A fifth push of PC=0x3010 is not stored. Popping 4 times returns 0x3000, 0x3004, 0x3008, 0x300C in order; then out_valid=0 and out_instr=0.
- At count=4, assert in_valid and out_ready together -> pop only, count=3. Next cycle push+pop -> count stays 3. Continue for 10 cycles, confirming pointer wrap with no reorder or loss.
- At count=3, assert flush together with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, out_pc=0x3000. The in-flight word is absent. A following push of PC=0x3020 appears at the head.
- Drive reset=1 at count=2 while in_valid=1 -> count=0, out_pc=0x3000, out_pc4=0x3004, no entry written.
- Push PC=0xFFFF_FFFC -> out_pc4=0x0000_0000.
